// File: rtl/lat_sram_pkg.sv
// Shared types and default latencies for the fixed-latency SRAM wrapper.
package lat_sram_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    localparam int DEF_RD_LAT = 3;
    localparam int DEF_WR_LAT = 4;
    localparam int CNT_W      = 8;
endpackage

// File: rtl/lat_sram_array.sv
// Single-port storage: byte-enabled synchronous write, combinational read of the addressed word.
module lat_sram_array
    import lat_sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/lat_sram.sv
// Fixed-latency single-port SRAM front end: one access at a time, round-robin
// read/write arbitration, out-of-range addresses flagged instead of stored.
module lat_sram
    import lat_sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int WR_LAT = DEF_WR_LAT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic                wr_ready,
    input  logic                rd_valid,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                oob
);
    localparam int               BE_W    = DATA_W / 8;
    localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WR_LAT - 1);
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

    if (RD_LAT < 1 || RD_LAT > 255) begin : g_bad_rd_lat
        $error("lat_sram: RD_LAT must be 1..255");
    end
    if (WR_LAT < 1 || WR_LAT > 255) begin : g_bad_wr_lat
        $error("lat_sram: WR_LAT must be 1..255");
    end
    if (DATA_W < 8 || DATA_W % 8 != 0) begin : g_bad_data_w
        $error("lat_sram: DATA_W must be a multiple of 8");
    end
    if (DEPTH < 1 || (ADDR_W < 31 && DEPTH > (1 << ADDR_W))) begin : g_bad_depth
        $error("lat_sram: DEPTH must be 1..2**ADDR_W");
    end

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              prio_wr;
    logic              oob_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              grant_rd, grant_wr, rd_capture, arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_rdata;

    // A conflict goes to whichever class was not served last; reads win after reset.
    assign grant_rd = (state == IDLE) && rd_valid && (!wr_valid || !prio_wr);
    assign grant_wr = (state == IDLE) && wr_valid && (!rd_valid ||  prio_wr);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_rd)      state_nxt = RD_WAIT;
                     else if (grant_wr) state_nxt = WR_WAIT;
            RD_WAIT: if (cnt == '0)     state_nxt = IDLE;
            WR_WAIT: if (cnt == '0)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_ready = (state == RD_WAIT) && (cnt == '0);
        wr_ready = (state == WR_WAIT) && (cnt == '0);
        oob      = (rd_ready || wr_ready) && oob_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            prio_wr <= 1'b0;
            oob_q   <= 1'b0;
        end else if (grant_rd) begin
            cnt     <= RD_CNT;
            prio_wr <= 1'b1;
            oob_q   <= !in_range(rd_addr);
        end else if (grant_wr) begin
            cnt     <= WR_CNT;
            prio_wr <= 1'b0;
            oob_q   <= !in_range(wr_addr);
        end else if (state != IDLE && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (grant_rd) begin
            addr_q <= rd_addr;
        end else if (grant_wr) begin
            addr_q  <= wr_addr;
            wdata_q <= wr_data;
            be_q    <= wr_be;
        end
    end

    // Read data is captured the edge before rd_ready; with RD_LAT=1 that is the accepting edge itself.
    assign arr_addr   = (state == IDLE) ? rd_addr : addr_q;
    assign rd_capture = (grant_rd && RD_LAT == 1) || (state == RD_WAIT && cnt == CNT_W'(1));
    assign arr_we     = rst_n && wr_ready && !oob_q;

    lat_sram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (wdata_q),
        .be    (be_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)          rd_data <= '0;
        else if (rd_capture) rd_data <= in_range(arr_addr) ? arr_rdata : '0;
    end
endmodule

// File: doc/lat_sram.md
LAT_SRAM -- requirements
Module: lat_sram

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 10: word-address width.
REQ-003 SHALL have parameter DEPTH, default 1024: implemented words; at most 2**ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 3: read latency in cycles, 1..255.
REQ-005 SHALL have parameter WR_LAT, default 4: write latency in cycles, 1..255.
REQ-006 SHALL have port clk  in  1: the only clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  in  1: reset, synchronous, active-low.
REQ-008 SHALL have port wr_valid  in  1: write request pending.
REQ-009 SHALL have port wr_addr  in  ADDR_W: write word address.
REQ-010 SHALL have port wr_data  in  DATA_W: write data.
REQ-011 SHALL have port wr_be  in  DATA_W/8: byte enables; bit i covers byte i.
REQ-012 SHALL have port wr_ready  out  1: one-cycle write-completion pulse.
REQ-013 SHALL have port rd_valid  in  1: read request pending.
REQ-014 SHALL have port rd_addr  in  ADDR_W: read word address.
REQ-015 SHALL have port rd_ready  out  1: one-cycle read-completion pulse.
REQ-016 SHALL have port rd_data  out  DATA_W: registered read data.
REQ-017 SHALL have port oob  out  1: pulses with wr_ready/rd_ready when the completing address is >= DEPTH.

Function
REQ-018 SHALL use FSM states IDLE, RD_WAIT, WR_WAIT, with one storage access at a time (single-port).
REQ-019 SHALL, in IDLE, accept a pending request in the same cycle: sample address, data and byte enables, then load the latency counter.
REQ-020 SHALL arbitrate IDLE read/write conflicts round-robin: the class not served last wins; read wins after reset.
REQ-021 SHALL assert rd_ready exactly RD_LAT cycles after acceptance, or wr_ready exactly WR_LAT cycles after acceptance, for one cycle; then return to IDLE.
REQ-022 SHALL ignore input changes after acceptance; the requester holds valid until ready, and the block treats valid still high in IDLE after completion as a new request.
REQ-023 SHALL commit a write on the clock edge that ends the wr_ready cycle, updating only enabled bytes.
REQ-024 SHALL drive rd_data with the addressed word in the rd_ready cycle and hold it until the next read completes.
REQ-025 SHALL return a just-completed write on a following read of the same address (no stale data).
REQ-026 SHALL sustain at most one transaction per LAT+1 cycles; latency 1 gives ready on the cycle after acceptance.
REQ-027 SHALL treat address >= DEPTH as out of bounds: write with no array change, read returning 0, oob pulsed.
REQ-028 SHALL write nothing when wr_be is all zeros, but still pulse wr_ready.

Reset
REQ-029 SHALL, when rst_n is low at a clock edge, set state IDLE, counter 0, wr_ready 0, rd_ready 0, oob 0, rd_data 0, and arbitration priority to read.
REQ-030 SHALL drop any transaction in flight at reset, with no array write and no ready pulse.
REQ-031 SHALL leave array contents unchanged by reset.

Structure
REQ-032 SHALL place the state typedef (IDLE/RD_WAIT/WR_WAIT) and default latency constants in package lat_sram_pkg.
REQ-033 SHALL isolate storage in sub-module lat_sram_array: one port, byte-enabled synchronous write, read of the addressed word.
REQ-034 SHALL reject illegal parameters (latency 0 or >255, DATA_W%8 != 0, DEPTH > 2**ADDR_W) at elaboration.

Verification
REQ-035 SHALL cover latency: write 0xDEADBEEF to addr 5 at cycle 0 -> wr_ready high at cycle 4 only; then read addr 5 -> rd_ready 3 cycles after acceptance with rd_data 0xDEADBEEF.
REQ-036 SHALL cover byte enables: addr 7 holds 0x11223344; write 0xAABBCCDD with be=0b0101 -> read gives 0x11BB33DD.
REQ-037 SHALL cover arbitration: rd_valid and wr_valid both high from reset, held -> order read, write, read, write; each ready pulse is exactly one cycle.
REQ-038 SHALL cover reset mid-write: rst_n low 2 cycles after write acceptance to addr 9 -> no wr_ready; addr 9 is unchanged on read-back.
REQ-039 SHALL cover out-of-bounds: DEPTH=1000, write to addr 1010 -> wr_ready and oob pulse together; read of addr 1010 -> rd_data 0, oob 1.
REQ-040 SHALL cover back-to-back: rd_valid held high with RD_LAT=1 -> rd_ready every 2nd cycle.
